// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: SPI mode-0 slave byte receiver with a first-word-fall-through FIFO
// presenting bytes to the command writer over valid/ready.
module spi_cmd_rx #(
   parameter int FIFO_AW     = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             in_main_clock,
   input  logic             in_reset,
   input  logic             in_spi_sck,
   input  logic             in_spi_mosi,
   input  logic             in_spi_cs_n,
   input  logic             in_byte_ready,
   output logic             out_byte_valid,
   output logic [7:0]       out_byte_data,
   output logic [FIFO_AW:0] out_fifo_level,
   output logic             out_overflow,
   output logic             out_frame_error
);
   typedef enum logic [1:0] {IDLE, SHIFT, ABORT} state_t;
   localparam int DEPTH = 1 << FIFO_AW;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic sck_s, mosi_s, cs_s, sck_d, cs_d, sck_rise, cs_rise;
   logic [2:0] cnt, cnt_nxt;
   logic [7:0] shift, shift_nxt;
   logic done, done_nxt, ferr_nxt;
   logic [7:0] mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic full, pop, wr_en;
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign cs_rise  = cs_s & ~cs_d;
   always_ff @(posedge in_main_clock) begin
      if (in_reset) begin
         sck_sync        <= '0;
         mosi_sync       <= '0;
         cs_sync         <= '1;
         sck_d           <= 1'b0;
         cs_d            <= 1'b1;
         state           <= ABORT;
         cnt             <= 3'd0;
         shift           <= 8'h00;
         done            <= 1'b0;
         out_frame_error <= 1'b0;
      end else begin
         sck_sync        <= {sck_sync[SYNC_STAGES-2:0], in_spi_sck};
         mosi_sync       <= {mosi_sync[SYNC_STAGES-2:0], in_spi_mosi};
         cs_sync         <= {cs_sync[SYNC_STAGES-2:0], in_spi_cs_n};
         sck_d           <= sck_s;
         cs_d            <= cs_s;
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         shift           <= shift_nxt;
         done            <= done_nxt;
         out_frame_error <= ferr_nxt;
      end
   end
   // SHIFT is only entered with CS low, so the first high CS seen there is always a rising edge
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt   = 3'd0;
            state_nxt = cs_s ? IDLE : SHIFT;
         end
         SHIFT: begin
            if (cs_rise) begin
               state_nxt = IDLE;
               cnt_nxt   = 3'd0;
               ferr_nxt  = cnt != 3'd0;
            end else if (sck_rise) begin
               shift_nxt = {shift[6:0], mosi_s};
               cnt_nxt   = cnt + 3'd1;
               done_nxt  = cnt == 3'd7;
            end
         end
         ABORT:   state_nxt = cs_s ? IDLE : ABORT;
         default: state_nxt = ABORT;
      endcase
   end
   assign out_fifo_level = wr_ptr - rd_ptr;
   assign out_byte_valid = out_fifo_level != '0;
   assign full           = out_fifo_level[FIFO_AW];
   assign pop            = out_byte_valid & in_byte_ready;
   assign wr_en          = done & (~full | pop);
   assign out_byte_data  = out_byte_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;
   always_ff @(posedge in_main_clock) begin
      if (in_reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
         if (done & full & ~pop) out_overflow <= 1'b1;
      end
   end
   always_ff @(posedge in_main_clock) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= shift;
   end
endmodule
